// File: rtl/fetch_pkg.sv
// fetch_pkg: opcodes and fetch FSM state encoding shared by the fetch stage.
package fetch_pkg;
    localparam int OP_W = 4;
    localparam logic [OP_W-1:0] OP_HALT = 4'b0000;
    localparam logic [OP_W-1:0] OP_JUMP = 4'b1110;
    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SLICE,
        HALT
    } fetch_state_e;
endpackage

// File: rtl/fetch_if.sv
// fetch_if: instruction-cache request/response bus plus issue handshake.
//   icache_req/icache_addr  fetch -> cache, block request held until icache_valid
//   icache_valid/block      cache -> fetch, one-cycle block delivery
//   issue_valid/inst/pc     fetch -> dispatcher, queue head
//   issue_ready             dispatcher -> fetch, head accepted when valid & ready
// master = fetch unit side, slave = cache/dispatcher side.
interface fetch_if #(
    parameter int WORD_SIZE  = 32,
    parameter int BLOCK_SIZE = 1024,
    parameter int ADDR_W     = 32
);
    logic                  icache_req;
    logic [ADDR_W-1:0]     icache_addr;
    logic                  icache_valid;
    logic [BLOCK_SIZE-1:0] icache_block;
    logic                  issue_valid;
    logic [WORD_SIZE-1:0]  issue_inst;
    logic [ADDR_W-1:0]     issue_pc;
    logic                  issue_ready;

    modport master (
        output icache_req, icache_addr, issue_valid, issue_inst, issue_pc,
        input  icache_valid, icache_block, issue_ready
    );

    modport slave (
        input  icache_req, icache_addr, issue_valid, issue_inst, issue_pc,
        output icache_valid, icache_block, issue_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO holding {instruction, pc} entries for issue.
//   push_i/data_i   write side; accepted when not full, or when full and popping
//   pop_i/data_o    read side; data_o is the head entry
//   flush_i         empties the queue (wins over push/pop)
//   full_o/empty_o  occupancy flags
module fetch_queue #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic             do_push, do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d = flush_i ? '0 : wr_q + PW'(do_push);
        rd_d = flush_i ? '0 : rd_q + PW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i)
            mem_q[wr_q[AW-1:0]] <= data_i;
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: fetches cache blocks, slices them into words in program order and
// queues them for the dispatcher.
//   clk, rst_n        clock, asynchronous active-low reset
//   start, start_pc   begin fetching at start_pc (honoured only in IDLE or HALT)
//   bus (master)      icache request/response and issue valid/ready handshake
//   busy              fetching (REQ or SLICE)
//   halted            halt opcode reached and every queued word issued
// Build option FETCH_JUMP_EN: opcode 4'b1110 redirects fetch to the zero-extended
// low bits of the instruction instead of being queued.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int WORD_SIZE   = 32,
    parameter int BLOCK_SIZE  = 1024,
    parameter int ADDR_W      = 32,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_pc,
    fetch_if.master           bus,
    output logic              busy,
    output logic              halted
);
    localparam int WPB         = BLOCK_SIZE / WORD_SIZE;
    localparam int WORD_BYTES  = WORD_SIZE / 8;
    localparam int BLOCK_BYTES = BLOCK_SIZE / 8;
    localparam int WP_W        = $clog2(WPB);
    localparam int OFF_LO      = $clog2(WORD_BYTES);
    localparam int OFF_HI      = $clog2(BLOCK_BYTES);
    localparam int QW          = WORD_SIZE + ADDR_W;

    fetch_state_e          state_q, state_d;
    logic [ADDR_W-1:0]     pc_q, pc_d;
    logic [WP_W-1:0]       wp_q, wp_d;
    logic [BLOCK_SIZE-1:0] block_q;
    logic [WORD_SIZE-1:0]  words [WPB];
    logic [WORD_SIZE-1:0]  inst;
    logic [OP_W-1:0]       op;
    logic                  req;
    logic                  q_push, q_pop, q_flush, q_full, q_empty, can_push;
    logic [QW-1:0]         q_dout;

    // Word 0 sits in the most significant bits of the block.
    for (genvar k = 0; k < WPB; k++) begin : g_word
        assign words[k] = block_q[BLOCK_SIZE-1-k*WORD_SIZE -: WORD_SIZE];
    end

    assign inst     = words[wp_q];
    assign op       = inst[WORD_SIZE-1 -: OP_W];
    assign req      = (state_q == REQ);
    assign q_pop    = !q_empty && bus.issue_ready;
    // A full queue still takes a word when the head leaves on the same edge.
    assign can_push = !q_full || q_pop;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        wp_d    = wp_q;
        q_push  = 1'b0;
        q_flush = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    pc_d    = start_pc;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.icache_valid) begin
                    wp_d    = pc_q[OFF_HI-1:OFF_LO];
                    state_d = SLICE;
                end
            end
            SLICE: begin
                if (op == OP_HALT)
                    state_d = HALT;
`ifdef FETCH_JUMP_EN
                else if (op == OP_JUMP) begin
                    pc_d    = ADDR_W'(inst[WORD_SIZE-OP_W-1:0]);
                    state_d = REQ;
                end
`endif
                else if (can_push) begin
                    q_push = 1'b1;
                    pc_d   = pc_q + ADDR_W'(WORD_BYTES);
                    wp_d   = wp_q + 1'b1;
                    // pc has already stepped onto the next block base here.
                    if (wp_q == WP_W'(WPB - 1))
                        state_d = REQ;
                end
            end
            HALT: begin
                if (start) begin
                    q_flush = 1'b1;
                    pc_d    = start_pc;
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
            wp_q    <= '0;
            block_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            wp_q    <= wp_d;
            if (req && bus.icache_valid)
                block_q <= bus.icache_block;
        end
    end

    fetch_queue #(
        .WIDTH (QW),
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (q_flush),
        .push_i  (q_push),
        .pop_i   (q_pop),
        .data_i  ({inst, pc_q}),
        .data_o  (q_dout),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    assign bus.icache_req                 = req;
    assign bus.icache_addr                = req ? (pc_q & ~ADDR_W'(BLOCK_BYTES - 1)) : '0;
    assign bus.issue_valid                = !q_empty;
    assign {bus.issue_inst, bus.issue_pc} = q_empty ? '0 : q_dout;
    assign busy                           = (state_q == REQ) || (state_q == SLICE);
    assign halted                         = (state_q == HALT) && q_empty;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vectors and corner-case sequences for fetch_unit.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [31:0] start_pc = '0;
    logic        busy, halted;

    fetch_if #(.WORD_SIZE(32), .BLOCK_SIZE(1024), .ADDR_W(32)) bus ();

    fetch_unit #(
        .WORD_SIZE   (32),
        .BLOCK_SIZE  (1024),
        .ADDR_W      (32),
        .QUEUE_DEPTH (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .start_pc (start_pc),
        .bus      (bus.master),
        .busy     (busy),
        .halted   (halted)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [31:0] halt_addr = 32'h7C;
    logic [31:0] halt2 = 32'hFFFF_FF00;
    logic [31:0] jump_addr = 32'hFFFF_FF04;
    int          lat = 0;
    bit          resp_en = 1'b1;
    bit          inject = 1'b0;

    int          nreq = 0;
    int          unstable = 0;
    logic [31:0] reqs [64];
    int          req_base = 0;
    logic        mon_p = 1'b0;
    logic [31:0] mon_pa = '0;
    int          rcnt = 0;

    typedef struct {
        logic [31:0] spc;
        logic [31:0] haddr;
        logic [31:0] h2;
        logic [31:0] jaddr;
        int          lat;
        int          rmode;
        int          exp_n;
        logic [31:0] exp_last;
        int          exp_nreq;
        logic [31:0] exp_req2;
    } vec_t;

    vec_t vecs [4];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == halt_addr || a == halt2) return 32'h0;
        if (a == jump_addr) return 32'hE000_0200;
        return {4'h1, a[27:0]};
    endfunction

    function automatic logic [1023:0] make_block(input logic [31:0] base);
        logic [1023:0] b;
        for (int k = 0; k < 32; k++) b[1023-k*32 -: 32] = mem_word(base + 32'(k * 4));
        return b;
    endfunction

    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        logic [31:0] n;
        n = pc + 32'd4;
`ifdef FETCH_JUMP_EN
        if (n == jump_addr) n = 32'h200;
`endif
        return n;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Instruction cache model: answers each request after `lat` cycles.
    initial begin
        bus.icache_valid = 1'b0;
        bus.icache_block = '0;
        forever begin
            @(negedge clk);
            if (!resp_en) begin
                bus.icache_valid = inject;
                bus.icache_block = make_block(32'h0);
            end else begin
                bus.icache_valid = 1'b0;
                if (bus.icache_req) begin
                    if (rcnt >= lat) begin
                        bus.icache_valid = 1'b1;
                        bus.icache_block = make_block(bus.icache_addr);
                        rcnt = 0;
                    end else rcnt++;
                end else rcnt = 0;
            end
        end
    end

    // Request log and address stability while a request is held.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.icache_req && mon_p && bus.icache_addr !== mon_pa) unstable++;
            if (bus.icache_req && !mon_p) begin
                if (nreq < 64) reqs[nreq] = bus.icache_addr;
                nreq++;
            end
            mon_p  = bus.icache_req;
            mon_pa = bus.icache_addr;
        end
    end

    task automatic set_mem(input logic [31:0] h, input logic [31:0] h2v, input logic [31:0] j, input int l);
        halt_addr = h;
        halt2     = h2v;
        jump_addr = j;
        lat       = l;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        bus.issue_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_start(input logic [31:0] pc);
        req_base = nreq;
        start    = 1'b1;
        start_pc = pc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic collect(input logic [31:0] spc, input int rmode, input int exp_n,
                           input logic [31:0] exp_last, input int exp_nreq, input logic [31:0] exp_req2);
        logic [31:0] epc;
        logic [31:0] last;
        int          n;
        bit          done;
        epc  = spc;
        last = 32'hDEAD_BEEF;
        n    = 0;
        done = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(negedge clk);
            bus.issue_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (halted) done = 1'b1;
            else if (bus.issue_valid && bus.issue_ready) begin
                chk("issue_pc", bus.issue_pc, epc);
                chk("issue_inst", bus.issue_inst, mem_word(epc));
                last = bus.issue_pc;
                n++;
                epc = next_pc(epc);
            end
        end
        chk("halted", 32'(halted), 32'd1);
        chk("busy_in_halt", 32'(busy), 32'd0);
        chk("issue_count", n, exp_n);
        chk("last_pc", last, exp_last);
        chk("req_count", nreq - req_base, exp_nreq);
        chk("req_addr_stable", unstable, 0);
        if (nreq - req_base > 0) chk("req1_addr", reqs[req_base], spc & ~32'h7F);
        if (exp_nreq > 1) chk("req2_addr", reqs[req_base+1], exp_req2);
    endtask

    initial begin
        vecs[0] = '{32'h0,  32'h7C,  32'hFFFF_FF00, 32'hFFFF_FF04, 0, 0, 31, 32'h78,  1, 32'h0};
        vecs[1] = '{32'h74, 32'h84,  32'hFFFF_FF00, 32'hFFFF_FF04, 2, 0, 4,  32'h80,  2, 32'h80};
`ifdef FETCH_JUMP_EN
        vecs[2] = '{32'h0,  32'h208, 32'h10,        32'h8,         1, 0, 4,  32'h204, 2, 32'h200};
`else
        vecs[2] = '{32'h0,  32'h208, 32'h10,        32'h8,         1, 0, 4,  32'hC,   1, 32'h0};
`endif
        vecs[3] = '{32'h40, 32'h108, 32'hFFFF_FF00, 32'hFFFF_FF04, 3, 1, 50, 32'h104, 3, 32'h80};

        bus.issue_ready = 1'b0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_req", 32'(bus.icache_req), 0);
        chk("rst_addr", bus.icache_addr, 0);
        chk("rst_valid", 32'(bus.issue_valid), 0);
        chk("rst_inst", bus.issue_inst, 0);
        chk("rst_pc", bus.issue_pc, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_halted", 32'(halted), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Two edges from icache_valid to the first issued word.
        set_mem(32'h7C, 32'hFFFF_FF00, 32'hFFFF_FF04, 0);
        bus.issue_ready = 1'b1;
        do_start(32'h10);
        @(negedge clk);
        chk("lat_not_yet", 32'(bus.issue_valid), 0);
        @(negedge clk);
        chk("lat_valid", 32'(bus.issue_valid), 1);
        chk("lat_pc", bus.issue_pc, 32'h10);
        collect(32'h14, 0, 26, 32'h78, 1, 32'h0);

        for (int i = 0; i < 4; i++) begin
            do_reset();
            set_mem(vecs[i].haddr, vecs[i].h2, vecs[i].jaddr, vecs[i].lat);
            do_start(vecs[i].spc);
            collect(vecs[i].spc, vecs[i].rmode, vecs[i].exp_n, vecs[i].exp_last, vecs[i].exp_nreq, vecs[i].exp_req2);
        end

        // Backpressure: queue fills, slicing stalls, nothing new requested.
        do_reset();
        set_mem(32'h7C, 32'hFFFF_FF00, 32'hFFFF_FF04, 0);
        do_start(32'h0);
        repeat (10) @(negedge clk);
        chk("bp_valid", 32'(bus.issue_valid), 1);
        chk("bp_pc", bus.issue_pc, 32'h0);
        chk("bp_inst", bus.issue_inst, 32'h1000_0000);
        chk("bp_no_req", 32'(bus.icache_req), 0);
        chk("bp_busy", 32'(busy), 1);
        chk("bp_halted", 32'(halted), 0);
        collect(32'h0, 0, 31, 32'h78, 1, 32'h0);

        // Long miss: request held steady, nothing issued before the block.
        do_reset();
        set_mem(32'h7C, 32'hFFFF_FF00, 32'hFFFF_FF04, 20);
        bus.issue_ready = 1'b1;
        do_start(32'h70);
        for (int c = 0; c < 19; c++) begin
            chk("miss_req", 32'(bus.icache_req), 1);
            chk("miss_addr", bus.icache_addr, 32'h0);
            chk("miss_valid", 32'(bus.issue_valid), 0);
            @(negedge clk);
        end
        collect(32'h70, 0, 3, 32'h78, 1, 32'h0);

        // Halt with words still queued, then restart elsewhere: old words flushed.
        do_reset();
        set_mem(32'h8, 32'h10C, 32'hFFFF_FF04, 0);
        do_start(32'h0);
        repeat (8) @(negedge clk);
        chk("hq_halted", 32'(halted), 0);
        chk("hq_busy", 32'(busy), 0);
        chk("hq_valid", 32'(bus.issue_valid), 1);
        chk("hq_pc", bus.issue_pc, 32'h0);
        do_start(32'h100);
        collect(32'h100, 0, 3, 32'h108, 1, 32'h0);

        // Reset while a request is outstanding; a stray valid afterwards is ignored.
        do_reset();
        set_mem(32'h7C, 32'hFFFF_FF00, 32'hFFFF_FF04, 50);
        do_start(32'h40);
        repeat (3) @(negedge clk);
        chk("mid_req", 32'(bus.icache_req), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_req", 32'(bus.icache_req), 0);
        chk("mid_rst_addr", bus.icache_addr, 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_valid", 32'(bus.issue_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        resp_en = 1'b0;
        inject = 1'b1;
        repeat (2) @(negedge clk);
        inject = 1'b0;
        repeat (3) @(negedge clk);
        chk("late_busy", 32'(busy), 0);
        chk("late_valid", 32'(bus.issue_valid), 0);
        chk("late_req", 32'(bus.icache_req), 0);
        resp_en = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
